// File: rtl/i2c_dri.sv
// -----------------------------------------------------------------------------
// i2c_dri : write-only SCCB/I2C master for sensor register setup.
//
// Each accepted request sends one frame:
//   START, {SLAVE_ADDR,W}, reg addr, reg data, STOP
// Every bit slot has four quarters of DIV clk cycles each. SCL is low in
// q0-q1 and high in q2-q3. SDA only changes at the start of q0.
//
// Optional build macro:
//   I2C_ACK_CHECK_EN - the ack-slot sample drives i2c_ack (1 = NACK seen).
//                      When it is not defined, i2c_ack is tied to 0 and the
//                      ack slot is a don't-care, as in SCCB. Frame timing is
//                      the same in both builds.
//
// Ports:
//   clk      in   system clock, rising edge only
//   rst_n    in   synchronous active-low reset
//   i2c_exec in   one-cycle write request (accepted only in IDLE)
//   i2c_data in   [15:8] register address, [7:0] register data
//   i2c_done out  one-cycle pulse in the first IDLE cycle after STOP
//   i2c_ack  out  NACK flag for the last frame
//   scl      out  bus clock, push-pull
//   sda      io   bus data, open-drain (drives 0 or releases)
// -----------------------------------------------------------------------------
module i2c_dri #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h21,
  parameter logic [25:0] CLK_FREQ   = 26'd50_000_000,
  parameter logic [17:0] I2C_FREQ   = 18'd250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic [15:0] i2c_data,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        scl,
  inout  wire         sda
);

  // Number of clk cycles in one quarter-bit phase.
  localparam int unsigned DIV    = 32'(CLK_FREQ) / (32'(I2C_FREQ) * 32'd4);
  localparam logic [7:0]  DIV_M1 = 8'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, SLADDR, REGADDR, WRDATA, STOP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_qcnt,  w_qcnt_nxt;   // cycle count inside a quarter
  logic [1:0]  r_q,     w_q_nxt;      // quarter index q0..q3
  logic [3:0]  r_bcnt,  w_bcnt_nxt;   // 0..7 data bits, 8 = ack slot
  logic [15:0] r_data,  w_data_nxt;
  logic        r_scl,   w_scl_nxt;
  logic        r_sda_oe, w_oe_nxt;    // 1 = pull sda low
  logic        r_done,  w_done_nxt;
  logic        r_ack;
  logic        w_qend, w_slot_end;

  // Bus levels for a given position in the frame. Returns {scl, sda_oe}.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic [3:0] b, input logic [15:0] d);
    logic [7:0] byt;
    logic [1:0] res;
    res = 2'b10;
    byt = 8'h00;
    case (st)
      SLADDR:  byt = {SLAVE_ADDR, 1'b0};
      REGADDR: byt = d[15:8];
      WRDATA:  byt = d[7:0];
      default: byt = 8'h00;
    endcase
    case (st)
      IDLE:  res = 2'b10;
      START: res = {(q != 2'd3), (q >= 2'd2)};
      SLADDR, REGADDR, WRDATA: begin
        // ~b[2:0] == 7-b, so bit 7 goes first.
        if (b == 4'd8) res = {(q >= 2'd2), 1'b0};
        else           res = {(q >= 2'd2), ~byt[~b[2:0]]};
      end
      STOP: begin
        case (q)
          2'd0:    res = 2'b01;
          2'd1:    res = 2'b11;
          default: res = 2'b10;
        endcase
      end
      default: res = 2'b10;
    endcase
    return res;
  endfunction

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_q_nxt     = r_q;
    w_bcnt_nxt  = r_bcnt;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_qend      = (r_qcnt == DIV_M1);
    w_slot_end  = w_qend && (r_q == 2'd3);
    if (r_state == IDLE) begin
      w_qcnt_nxt = 8'd0;
      w_q_nxt    = 2'd0;
      w_bcnt_nxt = 4'd0;
      if (i2c_exec) begin
        w_data_nxt  = i2c_data;
        w_state_nxt = START;
      end
    end else begin
      w_qcnt_nxt = w_qend ? 8'd0 : r_qcnt + 8'd1;
      if (w_qend) w_q_nxt = r_q + 2'd1;   // wraps q3 -> q0
      if (w_slot_end) begin
        case (r_state)
          START: begin
            w_state_nxt = SLADDR;
            w_bcnt_nxt  = 4'd0;
          end
          SLADDR, REGADDR, WRDATA: begin
            if (r_bcnt == 4'd8) begin
              w_bcnt_nxt = 4'd0;
              case (r_state)
                SLADDR:  w_state_nxt = REGADDR;
                REGADDR: w_state_nxt = WRDATA;
                default: w_state_nxt = STOP;
              endcase
            end else begin
              w_bcnt_nxt = r_bcnt + 4'd1;
            end
          end
          STOP: begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  // Bus outputs are registered from the next position to keep scl/sda glitch-free
  // while staying cycle-aligned with the state.
  assign {w_scl_nxt, w_oe_nxt} = bus_drive(w_state_nxt, w_q_nxt, w_bcnt_nxt, w_data_nxt);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_qcnt   <= 8'd0;
      r_q      <= 2'd0;
      r_bcnt   <= 4'd0;
      r_data   <= 16'h0000;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_q      <= w_q_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_data   <= w_data_nxt;
      r_scl    <= w_scl_nxt;
      r_sda_oe <= w_oe_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef I2C_ACK_CHECK_EN
  logic w_accept, w_smp;
  assign w_accept = (r_state == IDLE) && i2c_exec;
  // Ack sample: last cycle of q2 in an ack slot, while sda is released.
  assign w_smp = ((r_state == SLADDR) || (r_state == REGADDR) || (r_state == WRDATA)) &&
                 (r_bcnt == 4'd8) && (r_q == 2'd2) && w_qend;

  // Sticky within a frame, cleared by the next accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n)                        r_ack <= 1'b0;
    else if (w_accept)                 r_ack <= 1'b0;
    else if (w_smp && (sda == 1'b1))   r_ack <= 1'b1;
  end
`else
  // SCCB ignores the ack bit; the bus input is intentionally unused.
  logic w_unused_sda;
  assign w_unused_sda = sda;

  always_ff @(posedge clk) begin
    r_ack <= 1'b0;
  end
`endif

  assign scl      = r_scl;
  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign i2c_done = r_done;
  assign i2c_ack  = r_ack;

endmodule

// File: tb/tb_i2c_dri.sv
// -----------------------------------------------------------------------------
// tb_i2c_dri : directed self-checking bench for i2c_dri (default parameters,
// DIV = 50, so one frame is 116*50 = 5800 cycles).
// A small slave model decodes START/STOP, shifts in bits on scl rising edges
// and pulls sda low during ack slots (optionally not on the REGADDR ack).
// -----------------------------------------------------------------------------
module tb_i2c_dri;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_exec = 1'b0;
  logic [15:0] i2c_data = 16'h0000;
  logic        i2c_done, i2c_ack, scl;
  wire         sda;

  logic        slv_low  = 1'b0;
  logic        nack_sel = 1'b0;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_dri dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2c_exec (i2c_exec),
    .i2c_data (i2c_data),
    .i2c_done (i2c_done),
    .i2c_ack  (i2c_ack),
    .scl      (scl),
    .sda      (sda)
  );

`ifdef I2C_ACK_CHECK_EN
  localparam logic EXP_NACK = 1'b1;
`else
  localparam logic EXP_NACK = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave / bus monitor
  logic        p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0;
  int          idx = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;
  logic [26:0] cap = 27'd0;

  always @(negedge clk) begin
    if (p_scl && scl && p_sda && !sda) begin
      in_frame  <= 1'b1;
      idx       <= 0;
      cap       <= 27'd0;
      start_cnt <= start_cnt + 1;
    end else if (p_scl && scl && !p_sda && sda) begin
      stop_cnt <= stop_cnt + 1;
      in_frame <= 1'b0;
    end else if (!p_scl && scl && in_frame && idx < 27) begin
      cap <= {cap[25:0], sda};
      idx <= idx + 1;
    end
    if (p_scl && !scl)
      slv_low <= in_frame && ((idx == 8) || (idx == 17 && !nack_sel) || (idx == 26));
    if (i2c_done) done_cnt <= done_cnt + 1;
    p_scl <= scl;
    p_sda <= sda;
  end

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request; t0 = first cycle spent in START.
  task automatic start_frame(input logic [15:0] d, output int t0);
    @(negedge clk);
    i2c_exec = 1'b1;
    i2c_data = d;
    @(negedge clk);
    i2c_exec = 1'b0;
    t0 = cyc;
  endtask

  // Bounded wait for i2c_done; optionally issue the next request in that cycle.
  task automatic wait_done(input bit b2b, input logic [15:0] d2, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 8000 && !seen; i++) begin
      @(negedge clk);
      if (i2c_done) begin
        seen = 1'b1;
        at   = cyc;
        if (b2b) begin
          i2c_exec = 1'b1;
          i2c_data = d2;
        end
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2);
    chk({tag, "_nbits"}, idx, 27);
    chk({tag, "_byte0"}, {24'd0, cap[26:19]}, 32'h42);
    chk({tag, "_byte1"}, {24'd0, cap[17:10]}, {24'd0, b1});
    chk({tag, "_byte2"}, {24'd0, cap[8:1]},   {24'd0, b2});
  endtask

  int t0, t1, d1, d2, dc, sc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl",  {31'd0, scl},      32'd1);
    chk("rst_sda",  {31'd0, sda},      32'd1);
    chk("rst_done", {31'd0, i2c_done}, 32'd0);
    chk("rst_ack",  {31'd0, i2c_ack},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write 0x1280
    sc = stop_cnt;
    start_frame(16'h1280, t0);
    wait_done(1'b0, 16'h0, t1);
    chk("t1_latency", t1 - t0, 5800);
    check_frame("t1", 8'h12, 8'h80);
    chk("t1_acks", {29'd0, cap[18], cap[9], cap[0]}, 32'd0);
    chk("t1_ack",  {31'd0, i2c_ack}, 32'd0);
    chk("t1_stop", stop_cnt, sc + 1);
    @(negedge clk);
    chk("t1_done_width", {31'd0, i2c_done}, 32'd0);
    chk("t1_idle_scl",   {31'd0, scl}, 32'd1);
    chk("t1_idle_sda",   {31'd0, sda}, 32'd1);

    // Request while busy is ignored
    dc = done_cnt;
    sc = start_cnt;
    start_frame(16'h1280, t0);
    repeat (2000) @(negedge clk);
    i2c_exec = 1'b1;
    i2c_data = 16'h3d03;
    @(negedge clk);
    i2c_exec = 1'b0;
    wait_done(1'b0, 16'h0, t1);
    chk("t2_latency", t1 - t0, 5800);
    check_frame("t2", 8'h12, 8'h80);
    repeat (6000) @(negedge clk);
    chk("t2_done_cnt",  done_cnt,  dc + 1);
    chk("t2_start_cnt", start_cnt, sc + 1);

    // Back-to-back: next request in the done cycle
    start_frame(16'hA55A, t0);
    wait_done(1'b1, 16'h0FF0, d1);
    check_frame("t3a", 8'hA5, 8'h5A);
    @(negedge clk);
    i2c_exec = 1'b0;
    chk("t3_done_width", {31'd0, i2c_done}, 32'd0);
    wait_done(1'b0, 16'h0, d2);
    chk("t3_spacing", d2 - d1, 5801);
    check_frame("t3b", 8'h0F, 8'hF0);

    // NACK on the register-address ack
    nack_sel = 1'b1;
    sc = stop_cnt;
    start_frame(16'h5533, t0);
    wait_done(1'b0, 16'h0, t1);
    chk("t4_latency", t1 - t0, 5800);
    check_frame("t4", 8'h55, 8'h33);
    chk("t4_nack_bit",   {31'd0, cap[9]}, 32'd1);
    chk("t4_other_acks", {30'd0, cap[18], cap[0]}, 32'd0);
    chk("t4_ack",  {31'd0, i2c_ack}, {31'd0, EXP_NACK});
    chk("t4_stop", stop_cnt, sc + 1);
    nack_sel = 1'b0;
    start_frame(16'h1280, t0);
    chk("t4_ack_clear", {31'd0, i2c_ack}, 32'd0);
    wait_done(1'b0, 16'h0, t1);
    chk("t4_ack_after", {31'd0, i2c_ack}, 32'd0);

    // Reset mid-frame (slot 22, inside WRDATA)
    start_frame(16'h1280, t0);
    repeat (4475) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_scl",  {31'd0, scl},      32'd1);
    chk("t5_sda",  {31'd0, sda},      32'd1);
    chk("t5_done", {31'd0, i2c_done}, 32'd0);
    chk("t5_ack",  {31'd0, i2c_ack},  32'd0);
    dc = done_cnt;
    repeat (6000) @(negedge clk);
    chk("t5_no_done", done_cnt, dc);
    start_frame(16'hC3A5, t0);
    wait_done(1'b0, 16'h0, t1);
    chk("t5_latency", t1 - t0, 5800);
    check_frame("t5", 8'hC3, 8'hA5);
    chk("t5_acks", {29'd0, cap[18], cap[9], cap[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
